// File: rtl/lcd_pkg.sv
// Shared definitions for the RGB-LCD picture path: default 480x272 panel timing,
// RGB565 colour constants and the pixel type.
package lcd_pkg;
  typedef logic [15:0] pixel_t;

  localparam int LCD_H_SYNC   = 41;
  localparam int LCD_H_BACK   = 2;
  localparam int LCD_H_ACTIVE = 480;
  localparam int LCD_H_FRONT  = 2;
  localparam int LCD_V_SYNC   = 10;
  localparam int LCD_V_BACK   = 2;
  localparam int LCD_V_ACTIVE = 272;
  localparam int LCD_V_FRONT  = 2;

  localparam int PIC_AW = 9;

  localparam pixel_t RGB_BLACK = 16'h0000;
  localparam pixel_t RGB_RED   = 16'hF800;
  localparam pixel_t RGB_GREEN = 16'h07E0;
  localparam pixel_t RGB_BLUE  = 16'h001F;
  localparam pixel_t RGB_WHITE = 16'hFFFF;
endpackage

// File: rtl/lcd_timing_gen.sv
// Free-running h/v scan counters with raw sync and active-region decodes.
module lcd_timing_gen
  import lcd_pkg::*;
#(
  parameter int H_SYNC   = LCD_H_SYNC,
  parameter int H_BACK   = LCD_H_BACK,
  parameter int H_ACTIVE = LCD_H_ACTIVE,
  parameter int H_FRONT  = LCD_H_FRONT,
  parameter int V_SYNC   = LCD_V_SYNC,
  parameter int V_BACK   = LCD_V_BACK,
  parameter int V_ACTIVE = LCD_V_ACTIVE,
  parameter int V_FRONT  = LCD_V_FRONT,
  parameter int HW       = $clog2(H_SYNC + H_BACK + H_ACTIVE + H_FRONT),
  parameter int VW       = $clog2(V_SYNC + V_BACK + V_ACTIVE + V_FRONT)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  output logic [HW-1:0] h_cnt,
  output logic [VW-1:0] v_cnt,
  output logic          hs_raw,
  output logic          vs_raw,
  output logic          h_act,
  output logic          v_act,
  output logic          frame_end
);
  localparam int H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_SEND = HW'(H_SYNC);
  localparam logic [HW-1:0] H_ABEG = HW'(H_SYNC + H_BACK);
  localparam logic [HW-1:0] H_AEND = HW'(H_SYNC + H_BACK + H_ACTIVE);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_SEND = VW'(V_SYNC);
  localparam logic [VW-1:0] V_ABEG = VW'(V_SYNC + V_BACK);
  localparam logic [VW-1:0] V_AEND = VW'(V_SYNC + V_BACK + V_ACTIVE);

  logic [HW-1:0] h_cnt_q, h_cnt_d;
  logic [VW-1:0] v_cnt_q, v_cnt_d;

  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (!en) begin
      h_cnt_d = '0;
      v_cnt_d = '0;
    end else if (h_cnt_q == H_LAST) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + VW'(1);
    end else begin
      h_cnt_d = h_cnt_q + HW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  assign h_cnt     = h_cnt_q;
  assign v_cnt     = v_cnt_q;
  assign hs_raw    = (h_cnt_q >= H_SEND);
  assign vs_raw    = (v_cnt_q >= V_SEND);
  assign h_act     = (h_cnt_q >= H_ABEG) && (h_cnt_q < H_AEND);
  assign v_act     = (v_cnt_q >= V_ABEG) && (v_cnt_q < V_AEND);
  assign frame_end = (h_cnt_q == H_LAST) && (v_cnt_q == V_LAST);
endmodule

// File: rtl/lcd_pic_display.sv
// Places a small ROM picture in a window of the LCD scan; background colour elsewhere.
// All outputs are registered one clock behind the scan counters.
module lcd_pic_display
  import lcd_pkg::*;
#(
  parameter int     H_SYNC   = LCD_H_SYNC,
  parameter int     H_BACK   = LCD_H_BACK,
  parameter int     H_ACTIVE = LCD_H_ACTIVE,
  parameter int     H_FRONT  = LCD_H_FRONT,
  parameter int     V_SYNC   = LCD_V_SYNC,
  parameter int     V_BACK   = LCD_V_BACK,
  parameter int     V_ACTIVE = LCD_V_ACTIVE,
  parameter int     V_FRONT  = LCD_V_FRONT,
  parameter int     PIC_X    = 224,
  parameter int     PIC_Y    = 128,
  parameter int     PIC_W    = 32,
  parameter int     PIC_H    = 16,
  parameter pixel_t BG_COLOR = RGB_BLUE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  output logic [PIC_AW-1:0] pic_addr,
  input  pixel_t            pic_q,
  output logic              lcd_hs,
  output logic              lcd_vs,
  output logic              lcd_de,
  output pixel_t            lcd_rgb,
  output logic              frame_done
);
  localparam int HW = $clog2(H_SYNC + H_BACK + H_ACTIVE + H_FRONT);
  localparam int VW = $clog2(V_SYNC + V_BACK + V_ACTIVE + V_FRONT);

  localparam logic [HW-1:0]     H_OFF     = HW'(H_SYNC + H_BACK);
  localparam logic [HW-1:0]     X_LO      = HW'(PIC_X);
  localparam logic [HW-1:0]     X_HI      = HW'(PIC_X + PIC_W);
  localparam logic [VW-1:0]     V_OFF     = VW'(V_SYNC + V_BACK);
  localparam logic [VW-1:0]     Y_LO      = VW'(PIC_Y);
  localparam logic [VW-1:0]     Y_HI      = VW'(PIC_Y + PIC_H);
  localparam logic [PIC_AW-1:0] ADDR_LAST = PIC_AW'(PIC_W * PIC_H - 1);

  if (PIC_X + PIC_W > H_ACTIVE) begin : g_chk_x
    $fatal(1, "picture window exceeds active width");
  end
  if (PIC_Y + PIC_H > V_ACTIVE) begin : g_chk_y
    $fatal(1, "picture window exceeds active height");
  end
  if (PIC_W * PIC_H > 512) begin : g_chk_sz
    $fatal(1, "picture does not fit the 512-word ROM");
  end

  logic [HW-1:0] h_cnt, x;
  logic [VW-1:0] v_cnt, y;
  logic          hs_raw, vs_raw, h_act, v_act, frame_end, in_win;

  lcd_timing_gen #(
    .H_SYNC(H_SYNC), .H_BACK(H_BACK), .H_ACTIVE(H_ACTIVE), .H_FRONT(H_FRONT),
    .V_SYNC(V_SYNC), .V_BACK(V_BACK), .V_ACTIVE(V_ACTIVE), .V_FRONT(V_FRONT),
    .HW(HW), .VW(VW)
  ) u_timing (
    .clk(clk), .rst(rst), .en(en),
    .h_cnt(h_cnt), .v_cnt(v_cnt),
    .hs_raw(hs_raw), .vs_raw(vs_raw),
    .h_act(h_act), .v_act(v_act),
    .frame_end(frame_end)
  );

  // x/y wrap outside the active region, but are only used under h_act/v_act.
  assign x      = h_cnt - H_OFF;
  assign y      = v_cnt - V_OFF;
  assign in_win = h_act && v_act && (x >= X_LO) && (x < X_HI) && (y >= Y_LO) && (y < Y_HI);

  logic [PIC_AW-1:0] pic_addr_q, pic_addr_d;
  logic              lcd_hs_q, lcd_hs_d, lcd_vs_q, lcd_vs_d, lcd_de_q, lcd_de_d;
  logic              frame_done_q, frame_done_d;
  pixel_t            lcd_rgb_q, lcd_rgb_d;

  always_comb begin
    pic_addr_d   = pic_addr_q;
    lcd_hs_d     = 1'b1;
    lcd_vs_d     = 1'b1;
    lcd_de_d     = 1'b0;
    lcd_rgb_d    = RGB_BLACK;
    frame_done_d = 1'b0;
    // Raster-order counter; the frame-origin clear realigns it after any disturbance.
    if (!en || (h_cnt == '0 && v_cnt == '0))
      pic_addr_d = '0;
    else if (in_win)
      pic_addr_d = (pic_addr_q == ADDR_LAST) ? '0 : pic_addr_q + PIC_AW'(1);
    if (en) begin
      lcd_hs_d     = hs_raw;
      lcd_vs_d     = vs_raw;
      lcd_de_d     = h_act && v_act;
      lcd_rgb_d    = in_win ? pic_q : ((h_act && v_act) ? BG_COLOR : RGB_BLACK);
      frame_done_d = frame_end;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pic_addr_q   <= '0;
      lcd_hs_q     <= 1'b1;
      lcd_vs_q     <= 1'b1;
      lcd_de_q     <= 1'b0;
      lcd_rgb_q    <= RGB_BLACK;
      frame_done_q <= 1'b0;
    end else begin
      pic_addr_q   <= pic_addr_d;
      lcd_hs_q     <= lcd_hs_d;
      lcd_vs_q     <= lcd_vs_d;
      lcd_de_q     <= lcd_de_d;
      lcd_rgb_q    <= lcd_rgb_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign pic_addr   = pic_addr_q;
  assign lcd_hs     = lcd_hs_q;
  assign lcd_vs     = lcd_vs_q;
  assign lcd_de     = lcd_de_q;
  assign lcd_rgb    = lcd_rgb_q;
  assign frame_done = frame_done_q;
endmodule

// File: tb/tb_lcd_pic_display.sv
// Bench for lcd_pic_display: a shrunk-timing instance for full-frame checks, a
// top-left window override, and a default-timing instance checked on its first lines.
module tb_lcd_pic_display;
  localparam int HT = 56;           // 4+2+48+2
  localparam int F1 = HT * 31;      // 3+2+24+2 lines
  localparam int CAP = 6000;

  logic clk = 1'b0, rst = 1'b1, en = 1'b0;
  always #5 clk = ~clk;

  logic [8:0]  addr0, addr1, addr2;
  logic [15:0] rgb0, rgb1, rgb2, q0, q1, q2;
  logic        hs0, vs0, de0, fd0, hs1, vs1, de1, fd1, hs2, vs2, de2, fd2;
  assign q0 = {7'b0, addr0};
  assign q1 = {7'b0, addr1};
  assign q2 = {7'b0, addr2};

  lcd_pic_display dut0 (
    .clk(clk), .rst(rst), .en(en), .pic_addr(addr0), .pic_q(q0),
    .lcd_hs(hs0), .lcd_vs(vs0), .lcd_de(de0), .lcd_rgb(rgb0), .frame_done(fd0));

  lcd_pic_display #(
    .H_SYNC(4), .H_BACK(2), .H_ACTIVE(48), .H_FRONT(2),
    .V_SYNC(3), .V_BACK(2), .V_ACTIVE(24), .V_FRONT(2),
    .PIC_X(8), .PIC_Y(4), .PIC_W(32), .PIC_H(16)
  ) dut1 (
    .clk(clk), .rst(rst), .en(en), .pic_addr(addr1), .pic_q(q1),
    .lcd_hs(hs1), .lcd_vs(vs1), .lcd_de(de1), .lcd_rgb(rgb1), .frame_done(fd1));

  lcd_pic_display #(
    .H_SYNC(4), .H_BACK(2), .H_ACTIVE(48), .H_FRONT(2),
    .V_SYNC(3), .V_BACK(2), .V_ACTIVE(36), .V_FRONT(2),
    .PIC_X(0), .PIC_Y(0), .PIC_W(16), .PIC_H(32)
  ) dut2 (
    .clk(clk), .rst(rst), .en(en), .pic_addr(addr2), .pic_q(q2),
    .lcd_hs(hs2), .lcd_vs(vs2), .lcd_de(de2), .lcd_rgb(rgb2), .frame_done(fd2));

  int total = 0, bad = 0;
  int e_hs, e_vs, e_de, e_rgb, e_fd, n_hs, n_vs, n_de, n_fd, n_hs0, e_d0, e_idle;
  logic [15:0] cap1 [CAP];
  logic [15:0] cap2 [CAP];
  logic [8:0]  capa [CAP];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clr();
    e_hs = 0; e_vs = 0; e_de = 0; e_rgb = 0; e_fd = 0;
    n_hs = 0; n_vs = 0; n_de = 0; n_fd = 0; n_hs0 = 0; e_d0 = 0;
  endtask

  // Sample s is taken after the s+1-th enabled edge, i.e. it shows counter state s.
  task automatic scan(input int n, input bit first);
    for (int s = 0; s < n; s++) begin
      int p, h, v, x, y;
      bit act, win;
      logic [15:0] er;
      @(negedge clk);
      p = s % F1; h = p % HT; v = p / HT; x = h - 6; y = v - 5;
      act = (h >= 6) && (h < 54) && (v >= 5) && (v < 29);
      win = act && (x >= 8) && (x < 40) && (y >= 4) && (y < 20);
      er  = win ? 16'((y - 4) * 32 + (x - 8)) : (act ? 16'h001F : 16'h0000);
      if (hs1 !== (h >= 4)) e_hs++;
      if (vs1 !== (v >= 3)) e_vs++;
      if (de1 !== act) e_de++;
      if (rgb1 !== er) e_rgb++;
      if (fd1 !== (p == F1 - 1)) e_fd++;
      if (s < 3 * F1) begin
        if (!hs1) n_hs++;
        if (!vs1) n_vs++;
        if (de1) n_de++;
        if (fd1) n_fd++;
      end
      if (s < CAP) begin
        cap1[s] = rgb1; capa[s] = addr1; cap2[s] = rgb2;
      end
      if (first && s < 1050) begin
        if (!hs0) n_hs0++;
        if (vs0 || de0) e_d0++;
      end
    end
  endtask

  task automatic chk_errs(input string tag);
    chk({tag, "_hs"}, e_hs, 0);
    chk({tag, "_vs"}, e_vs, 0);
    chk({tag, "_de"}, e_de, 0);
    chk({tag, "_rgb"}, e_rgb, 0);
    chk({tag, "_fd"}, e_fd, 0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_hs"}, hs1, 1);
    chk({tag, "_vs"}, vs1, 1);
    chk({tag, "_de"}, de1, 0);
    chk({tag, "_rgb"}, rgb1, 0);
    chk({tag, "_fd"}, fd1, 0);
    chk({tag, "_addr"}, addr1, 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk_reset_vals("rst");
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_hs", hs1, 1);
    chk("idle_de0", hs0, 1);

    en = 1'b1;
    clr();
    scan(3 * F1 + 601, 1'b1);
    chk_errs("f3");
    chk("hs_low_cnt", n_hs, 3 * 4 * 31);
    chk("vs_low_cnt", n_vs, 3 * 3 * HT);
    chk("de_cnt", n_de, 3 * 48 * 24);
    chk("fd_cnt", n_fd, 3);
    chk("rgb_first", cap1[518], 16'h0000);
    chk("rgb_row0_end", cap1[549], 16'h001F);
    chk("rgb_row1_start", cap1[574], 16'h0020);
    chk("rgb_last", cap1[1389], 16'h01FF);
    chk("rgb_left_bg", cap1[517], 16'h001F);
    chk("addr_adv", capa[518], 1);
    chk("addr_wrap", capa[1389], 0);
    chk("tl_first", cap2[286], 16'h0000);
    chk("tl_row1", cap2[342], 16'h0010);
    chk("tl_511", cap2[2037], 16'h01FF);
    chk("tl_right_bg", cap2[2038], 16'h001F);
    chk("tl_next_frame", cap2[2694], 16'h0000);
    chk("dflt_hs_low", n_hs0, 82);
    chk("dflt_vs_de", e_d0, 0);

    // Drop enable inside the window of the fourth frame.
    en = 1'b0;
    e_idle = 0;
    repeat (100) begin
      @(negedge clk);
      if (hs1 !== 1'b1 || vs1 !== 1'b1 || de1 !== 1'b0 || rgb1 !== 16'h0 ||
          fd1 !== 1'b0 || addr1 !== 9'h0) e_idle++;
    end
    chk("abort_idle", e_idle, 0);
    en = 1'b1;
    clr();
    scan(F1, 1'b0);
    chk_errs("resume");
    chk("resume_fd_cnt", n_fd, 1);
    chk("resume_addr0", capa[517], 0);
    chk("resume_first", cap1[518], 16'h0000);
    chk("resume_last", cap1[1389], 16'h01FF);

    clr();
    scan(15 * HT + 27, 1'b0);
    chk("pre_rst_de", de1, 1);
    rst = 1'b1;
    #1;
    chk_reset_vals("async_rst");
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rel_hs_high", hs1, 1);
    clr();
    scan(F1, 1'b0);
    chk_errs("post_rst");
    chk("post_rst_fd", n_fd, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/lcd_pic_display.md
Name: lcd_pic_display

Overview:
- Downstream consumer of the pic_ram picture ROM (9-bit address, 16-bit RGB565 word, combinational read).
- Generates RGB-LCD timing (hs/vs/de) and drives pic_addr while the scan is inside a picture window.
- Outputs pic_q as the pixel colour inside the window and a constant background colour elsewhere.
- Sits between the picture ROM and the LCD pins.

Parameters:
- H_SYNC, 41, hsync pulse width in clocks
- H_BACK, 2, horizontal back porch
- H_ACTIVE, 480, visible pixels per line
- H_FRONT, 2, horizontal front porch
- V_SYNC, 10, vsync pulse width in lines
- V_BACK, 2, vertical back porch
- V_ACTIVE, 272, visible lines
- V_FRONT, 2, vertical front porch
- PIC_X, 224, window left column in active coordinates
- PIC_Y, 128, window top row in active coordinates
- PIC_W, 32, picture width in pixels
- PIC_H, 16, picture height in lines; PIC_W*PIC_H <= 512
- BG_COLOR, 16'h001F, RGB565 colour outside the window

Ports:
- clk  in  1  pixel clock
- rst  in  1  asynchronous reset, active-high
- en  in  1  display enable; low holds the scan idle
- pic_addr  out  9  address to the picture ROM
- pic_q  in  16  ROM data, valid in the same cycle as pic_addr
- lcd_hs  out  1  horizontal sync, active-low
- lcd_vs  out  1  vertical sync, active-low
- lcd_de  out  1  data enable, high on visible pixels
- lcd_rgb  out  16  RGB565 pixel
- frame_done  out  1  one-cycle pulse at the end of each frame

Behaviour:
- Reset is asynchronous, active-high. Reset values: lcd_hs=1, lcd_vs=1, lcd_de=0, lcd_rgb=0, frame_done=0, pic_addr=0, h_cnt=0, v_cnt=0.
- Totals: H_TOTAL = H_SYNC+H_BACK+H_ACTIVE+H_FRONT (525). V_TOTAL = V_SYNC+V_BACK+V_ACTIVE+V_FRONT (286).
- h_cnt counts 0..H_TOTAL-1, then wraps to 0.
- v_cnt increments when h_cnt wraps, and wraps to 0 after V_TOTAL-1.
- Sync and active regions:
  - hs_raw = 0 while h_cnt < H_SYNC. vs_raw = 0 while v_cnt < V_SYNC.
  - h_act when H_SYNC+H_BACK <= h_cnt < H_SYNC+H_BACK+H_ACTIVE. v_act is defined the same way on v_cnt.
  - x = h_cnt-(H_SYNC+H_BACK), y = v_cnt-(V_SYNC+V_BACK).
  - in_win = h_act & v_act & PIC_X <= x < PIC_X+PIC_W & PIC_Y <= y < PIC_Y+PIC_H.
- Address generation (no multiplier):
  - pic_addr is a registered counter holding the address of the pixel currently addressed by h_cnt/v_cnt.
  - On each in_win cycle, pic_addr advances by 1 at the clock edge.
  - After PIC_W*PIC_H-1 it returns to 0.
  - It is also forced to 0 when h_cnt=0 and v_cnt=0, which resyncs every frame.
- Output stage: one register stage, so every output is exactly 1 clock behind its counters.
  - lcd_hs <= hs_raw; lcd_vs <= vs_raw; lcd_de <= h_act & v_act.
  - lcd_rgb <= in_win ? pic_q : (h_act & v_act ? BG_COLOR : 0).
- frame_done <= (h_cnt==H_TOTAL-1 & v_cnt==V_TOTAL-1 & en). It is high for exactly one cycle.
- en low:
  - Next edge: counters and pic_addr forced to 0.
  - Outputs take idle values (hs=1, vs=1, de=0, rgb=0, frame_done=0).
  - Deasserting en mid-frame aborts the frame. No frame_done is produced.
- en rising: the scan starts at h_cnt=0, v_cnt=0. The first lcd_hs low appears 1 clock later.
- Reset mid-frame: all state returns to reset values immediately. The scan restarts from 0 after rst falls, if en=1.
- Elaboration checks (fatal): PIC_X+PIC_W <= H_ACTIVE, PIC_Y+PIC_H <= V_ACTIVE, PIC_W*PIC_H <= 512.
- Counter widths: h_cnt is $clog2(H_TOTAL) bits and v_cnt is $clog2(V_TOTAL) bits. Comparisons are unsigned with no overflow.

Decomposition:
- Package lcd_pkg holds:
  - default timing constants for the 480x272 panel;
  - RGB565 colour constants (black, red, green, blue, white);
  - the pixel type (16-bit RGB565).
- Sub-module lcd_timing_gen provides:
  - outputs h_cnt, v_cnt, hs_raw, vs_raw, h_act, v_act and frame-end;
  - parameters for the eight timing values.
- lcd_pic_display instantiates lcd_timing_gen and adds the window logic, address counter and output register.

Test Plan:
- Reset then en=1, run 2 frames -> lcd_hs low for 41 clocks every 525; lcd_vs low for 10 lines every 286; lcd_de high 480 clocks per line on 272 lines per frame.
- ROM model with pic_q = {7'b0, pic_addr} -> first window pixel (x=224, y=128) shows rgb=0x0000. Pixel (x=255, y=128) shows 0x001F, pixel (x=224, y=129) shows 0x0020, last pixel shows 0x01FF. All visible pixels outside the window show 0x001F.
- Count frame_done pulses over 3 frames -> exactly 3, each 1 clock wide. Each is asserted 1 clock after h_cnt=524, v_cnt=285.
- Deassert en mid-window, reassert after 100 clocks -> outputs idle while en=0. pic_addr restarts at 0, the next frame is pixel-identical to a clean frame, and the aborted frame gives no frame_done.
- Assert rst for 3 clocks at line 150, x=240 -> all outputs at reset values asynchronously. After release, the first lcd_hs fall is 1 clock after the first enabled edge.
- Parameter override PIC_W=16, PIC_H=32, PIC_X=0, PIC_Y=0 -> window at the top-left. Address 511 is at (15,31) and 0 reappears in the next frame.
